// File: rtl/lmmi_cfg_pkg.sv
// Shared constants for the LMMI configuration-port arbiter: FSM state encodings
// and the default LMMI bus widths used by LIFCL hard IP.
package lmmi_cfg_pkg;

  localparam int LMMI_OFFSET_W = 7;
  localparam int LMMI_DATA_W   = 8;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ISSUE   = 2'd1;
  localparam logic [1:0] ST_WAIT_RD = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

endpackage

// File: rtl/lmmi_cfg_arbiter_rr.sv
// Combinational round-robin picker: the first set request strictly after ptr
// (wrapping) wins, so the last winner gets lowest priority next time.
module rr_arbiter
  import lmmi_cfg_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          any
);

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    for (int i = 1; i <= N; i++) begin
      if (!any && req[(int'(ptr) + i) % N]) begin
        any                          = 1'b1;
        grant[(int'(ptr) + i) % N]   = 1'b1;
        grant_idx                    = IW'((int'(ptr) + i) % N);
      end
    end
  end

endmodule

// File: rtl/lmmi_cfg_arbiter.sv
// Shares one LMMI config port among N_REQ fabric requesters: round-robin grant,
// one transaction in flight, per-transaction timeout so a hung IP cannot lock the port.
module lmmi_cfg_arbiter
  import lmmi_cfg_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int OFFSET_W    = LMMI_OFFSET_W,
  parameter int DATA_W      = LMMI_DATA_W,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                         lmmi_clk,
  input  logic                         lmmi_resetn,
  input  logic [N_REQ-1:0]             req_valid,
  input  logic [N_REQ-1:0]             req_wr_rdn,
  input  logic [N_REQ*OFFSET_W-1:0]    req_offset,
  input  logic [N_REQ*DATA_W-1:0]      req_wdata,
  output logic [N_REQ-1:0]             req_ack,
  output logic [DATA_W-1:0]            rsp_rdata,
  output logic                         rsp_err,
  output logic                         lmmi_request,
  output logic                         lmmi_wr_rdn,
  output logic [OFFSET_W-1:0]          lmmi_offset,
  output logic [DATA_W-1:0]            lmmi_wdata,
  input  logic                         lmmi_ready,
  input  logic                         lmmi_rdata_valid,
  input  logic [DATA_W-1:0]            lmmi_rdata
);

  localparam int IW = $clog2(N_REQ);
  localparam int TW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

  state_t                state;
  logic [IW-1:0]         ptr;
  logic [N_REQ-1:0]      gnt_oh;
  logic [N_REQ-1:0]      arb_gnt;
  logic [IW-1:0]         arb_idx;
  logic                  arb_any;
  logic                  cmd_wr;
  logic [OFFSET_W-1:0]   cmd_offset;
  logic [DATA_W-1:0]     cmd_wdata;
  logic [TW-1:0]         timer;
  logic                  timeout_hit;

  rr_arbiter #(.N(N_REQ)) u_rr (
    .req       (req_valid),
    .ptr       (ptr),
    .grant     (arb_gnt),
    .grant_idx (arb_idx),
    .any       (arb_any)
  );

  // >= rather than == so a read that moved to WAIT_RD on its last allowed cycle still aborts.
  assign timeout_hit = (TIMEOUT_CYC != 0) && (timer >= TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge lmmi_clk or negedge lmmi_resetn) begin
    if (!lmmi_resetn) begin
      state      <= ST_IDLE;
      ptr        <= IW'(N_REQ - 1);
      gnt_oh     <= '0;
      cmd_wr     <= 1'b0;
      cmd_offset <= '0;
      cmd_wdata  <= '0;
      timer      <= '0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (arb_any) begin
            ptr        <= arb_idx;
            gnt_oh     <= arb_gnt;
            cmd_wr     <= req_wr_rdn[arb_idx];
            cmd_offset <= req_offset[arb_idx*OFFSET_W +: OFFSET_W];
            cmd_wdata  <= req_wdata[arb_idx*DATA_W +: DATA_W];
            timer      <= '0;
            state      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (timer != {TW{1'b1}}) timer <= timer + 1'b1;
          if (lmmi_ready) begin
            if (cmd_wr) begin
              rsp_rdata <= '0;
              rsp_err   <= 1'b0;
              state     <= ST_DONE;
            end else if (lmmi_rdata_valid) begin
              rsp_rdata <= lmmi_rdata;
              rsp_err   <= 1'b0;
              state     <= ST_DONE;
            end else begin
              state <= ST_WAIT_RD;
            end
          end else if (timeout_hit) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_WAIT_RD: begin
          if (timer != {TW{1'b1}}) timer <= timer + 1'b1;
          if (lmmi_rdata_valid) begin
            rsp_rdata <= lmmi_rdata;
            rsp_err   <= 1'b0;
            state     <= ST_DONE;
          end else if (timeout_hit) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  assign lmmi_request = (state == ST_ISSUE);
  assign lmmi_wr_rdn  = cmd_wr;
  assign lmmi_offset  = cmd_offset;
  assign lmmi_wdata   = cmd_wdata;
  assign req_ack      = (state == ST_DONE) ? gnt_oh : '0;

endmodule
